// File: rtl/up_down_counter_7_segment_pkg.sv
// Shared widths, active-low 7-segment glyphs and the digit-to-glyph map for
// the up/down counter display block.
package up_down_counter_pkg;

  localparam int SEG_WIDTH   = 7;
  localparam int DIGIT_WIDTH = 4;

  // Active-low glyphs, bit order {A,B,C,D,E,F,G} with A as the MSB.
  localparam logic [SEG_WIDTH-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_WIDTH-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_WIDTH-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_WIDTH-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_WIDTH-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_WIDTH-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_WIDTH-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_WIDTH-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_WIDTH-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_WIDTH-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_WIDTH-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_WIDTH-1:0] SEG_B     = 7'b1100000;
  localparam logic [SEG_WIDTH-1:0] SEG_C     = 7'b0110001;
  localparam logic [SEG_WIDTH-1:0] SEG_D     = 7'b1000010;
  localparam logic [SEG_WIDTH-1:0] SEG_E     = 7'b0110000;
  localparam logic [SEG_WIDTH-1:0] SEG_F     = 7'b0111000;
  localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'b1111111;

  // Per-cycle action on the count, resolved from the switch pulses.
  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_CLEAR
  } step_e;

  function automatic logic [SEG_WIDTH-1:0] digit_to_seg(input logic [DIGIT_WIDTH-1:0] digit);
    logic [SEG_WIDTH-1:0] seg;
    seg = SEG_BLANK;
    case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/up_down_counter_7_segment_switch_debounce_edge.sv
// Debounce one raw push switch and emit a single-cycle pulse on each
// debounced press (low-to-high transition of the filtered level).
module switch_debounce_edge #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Rise
);

  localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             level_prev_q;

  // Count cycles of disagreement; accept the raw value once it has held long enough.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (i_Switch == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      level_q <= i_Switch;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Remember last cycle's level so a press yields exactly one rise pulse.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) level_prev_q <= 1'b0;
    else          level_prev_q <= level_q;
  end

  assign o_Level = level_q;
  assign o_Rise  = level_q & ~level_prev_q;

endmodule

// File: rtl/up_down_counter_7_segment.sv
// Multi-digit hex/BCD up/down counter driven by three debounced push
// switches (up, down, clear) with registered active-low 7-segment outputs.
// Optional hold-to-repeat on up/down: define UP_DOWN_COUNTER_AUTO_REPEAT_EN.
module up_down_counter_7_segment
  import up_down_counter_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HEX_MODE       = 1,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_RATE    = 2500000
) (
  input  logic                            i_Clk,
  input  logic                            i_Rst_L,
  input  logic                            i_Switch_Up,
  input  logic                            i_Switch_Down,
  input  logic                            i_Switch_Clear,
  output logic [DIGIT_WIDTH*NUM_DIGITS-1:0] o_Count,
  output logic [SEG_WIDTH*NUM_DIGITS-1:0]   o_Segments,
  output logic                            o_Wrap
);

  // Switch index: 0 = up, 1 = down, 2 = clear.
  localparam int NUM_SW = 3;

  logic [NUM_SW-1:0] sw_raw;
  logic [NUM_SW-1:0] sw_level;
  logic [NUM_SW-1:0] sw_rise;

  logic step_up;
  logic step_dn;
  step_e step;

  logic [NUM_DIGITS-1:0][DIGIT_WIDTH-1:0] count_q;
  logic [NUM_DIGITS-1:0][DIGIT_WIDTH-1:0] inc_val;
  logic [NUM_DIGITS-1:0][DIGIT_WIDTH-1:0] dec_val;
  logic                                   inc_wrap;
  logic                                   dec_wrap;
  logic                                   wrap_q;
  logic [NUM_DIGITS-1:0][SEG_WIDTH-1:0]   seg_q;

  assign sw_raw = {i_Switch_Clear, i_Switch_Down, i_Switch_Up};

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    switch_debounce_edge #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_sw (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Switch(sw_raw[i]),
      .o_Level (sw_level[i]),
      .o_Rise  (sw_rise[i])
    );
  end

`ifdef UP_DOWN_COUNTER_AUTO_REPEAT_EN
  // Hold counter runs from the first debounced-high cycle (0). It fires at
  // REPEAT_DELAY, then reloads so the next fire is REPEAT_RATE cycles later.
  // Expects 1 <= REPEAT_RATE <= REPEAT_DELAY + 1.
  localparam int HOLD_W = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_FIRE   = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE + 1);

  logic [1:0] rep_pulse;
  logic       unused_clr_level;

  // Clear never repeats, so its level is not needed.
  assign unused_clr_level = sw_level[2];

  for (genvar i = 0; i < 2; i++) begin : g_hold
    logic [HOLD_W-1:0] hold_q;

    assign rep_pulse[i] = sw_level[i] && (hold_q == HOLD_FIRE);

    // Track hold time while the debounced level stays high; clear on release.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L)          hold_q <= '0;
      else if (!sw_level[i]) hold_q <= '0;
      else if (rep_pulse[i]) hold_q <= HOLD_RELOAD;
      else                   hold_q <= hold_q + 1'b1;
    end
  end

  assign step_up = sw_rise[0] | rep_pulse[0];
  assign step_dn = sw_rise[1] | rep_pulse[1];
`else
  logic unused_cfg;

  // Without repeat, levels and repeat timing have no consumer.
  assign unused_cfg = ^{sw_level, 32'(REPEAT_DELAY), 32'(REPEAT_RATE)};

  assign step_up = sw_rise[0];
  assign step_dn = sw_rise[1];
`endif

  // Resolve this cycle's action: clear wins, opposing steps cancel.
  always_comb begin
    step = STEP_NONE;
    if (sw_rise[2])              step = STEP_CLEAR;
    else if (step_up && step_dn) step = STEP_NONE;
    else if (step_up)            step = STEP_UP;
    else if (step_dn)            step = STEP_DOWN;
  end

  if (HEX_MODE != 0) begin : g_hex
    assign inc_val  = count_q + 1'b1;
    assign dec_val  = count_q - 1'b1;
    assign inc_wrap = &count_q;
    assign dec_wrap = ~|count_q;
  end else begin : g_bcd
    logic carry;
    logic borrow;

    // Ripple decimal carry/borrow digit by digit; a carry/borrow out of the
    // top digit is the wrap condition.
    always_comb begin
      inc_val = count_q;
      dec_val = count_q;
      carry   = 1'b1;
      borrow  = 1'b1;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (carry) begin
          if (count_q[d] == 4'd9) begin
            inc_val[d] = 4'd0;
          end else begin
            inc_val[d] = count_q[d] + 4'd1;
            carry      = 1'b0;
          end
        end
        if (borrow) begin
          if (count_q[d] == 4'd0) begin
            dec_val[d] = 4'd9;
          end else begin
            dec_val[d] = count_q[d] - 4'd1;
            borrow     = 1'b0;
          end
        end
      end
      inc_wrap = carry;
      dec_wrap = borrow;
    end
  end

  // Apply the step; the wrap pulse lands in the same cycle as the new count.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (step)
        STEP_CLEAR: count_q <= '0;
        STEP_UP: begin
          count_q <= inc_val;
          wrap_q  <= inc_wrap;
        end
        STEP_DOWN: begin
          count_q <= dec_val;
          wrap_q  <= dec_wrap;
        end
        default: ;
      endcase
    end
  end

  // Register the glyphs so the display lines are glitch-free.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      seg_q <= {NUM_DIGITS{SEG_0}};
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++) seg_q[d] <= digit_to_seg(count_q[d]);
    end
  end

  assign o_Count    = count_q;
  assign o_Segments = seg_q;
  assign o_Wrap     = wrap_q;

endmodule

// File: tb/tb_up_down_counter_7_segment.sv
// Directed bench: a hex instance and a BCD instance of the counter, each
// with its own switch inputs, checked against hand-computed values.
module tb_up_down_counter_7_segment;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G9 = 7'b0000100;
  localparam logic [6:0] GF = 7'b0111000;

  logic i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  logic        rst_l;
  logic        h_up, h_dn, h_clr, b_up, b_dn, b_clr;
  logic [7:0]  h_count, b_count;
  logic [13:0] h_seg, b_seg;
  logic        h_wrap, b_wrap;

  int checks = 0;
  int failures = 0;
  int wrap_cnt = 0;
  int misaligned = 0;
  int bad_digit = 0;

  up_down_counter_7_segment #(
    .NUM_DIGITS(2), .DEBOUNCE_LIMIT(4), .HEX_MODE(1), .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) u_hex (
    .i_Clk(i_Clk), .i_Rst_L(rst_l), .i_Switch_Up(h_up), .i_Switch_Down(h_dn),
    .i_Switch_Clear(h_clr), .o_Count(h_count), .o_Segments(h_seg), .o_Wrap(h_wrap)
  );

  up_down_counter_7_segment #(
    .NUM_DIGITS(2), .DEBOUNCE_LIMIT(4), .HEX_MODE(0), .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) u_bcd (
    .i_Clk(i_Clk), .i_Rst_L(rst_l), .i_Switch_Up(b_up), .i_Switch_Down(b_dn),
    .i_Switch_Clear(b_clr), .o_Count(b_count), .o_Segments(b_seg), .o_Wrap(b_wrap)
  );

  function automatic logic [7:0] cur(input bit bcd);
    return bcd ? b_count : h_count;
  endfunction

  function automatic logic cur_wrap(input bit bcd);
    return bcd ? b_wrap : h_wrap;
  endfunction

  // sw bits: {clear, down, up}
  task automatic set_sw(input bit bcd, input logic [2:0] sw);
    if (bcd) {b_clr, b_dn, b_up} = sw;
    else     {h_clr, h_dn, h_up} = sw;
  endtask

  // One clean press: 6 cycles high, 6 low, sampling wrap and digits each cycle.
  task automatic press(input bit bcd, input logic [2:0] sw);
    logic [7:0] prev;
    prev = cur(bcd);
    set_sw(bcd, sw);
    for (int i = 0; i < 12; i++) begin
      @(negedge i_Clk);
      if (i == 5) set_sw(bcd, 3'b000);
      if (cur_wrap(bcd)) begin
        wrap_cnt++;
        if (cur(bcd) == prev) misaligned++;
      end
      if (bcd && (b_count[3:0] > 4'd9 || b_count[7:4] > 4'd9)) bad_digit++;
      prev = cur(bcd);
    end
  endtask

  task automatic test_reset;
    rst_l = 1'b0;
    set_sw(0, 3'b000);
    set_sw(1, 3'b000);
    repeat (3) @(negedge i_Clk);
    checks++; if (h_count !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=%h", h_count, 8'h00); end
    checks++; if (h_seg !== {G0, G0}) begin failures++; $display("FAIL reset_seg got=%b exp=%b", h_seg, {G0, G0}); end
    checks++; if (h_wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", h_wrap); end
    checks++; if (b_count !== 8'h00) begin failures++; $display("FAIL reset_bcd_count got=%h exp=%h", b_count, 8'h00); end
    rst_l = 1'b1;
    repeat (4) @(negedge i_Clk);
    checks++; if (h_count !== 8'h00) begin failures++; $display("FAIL reset_release_count got=%h exp=%h", h_count, 8'h00); end
  endtask

  task automatic test_bounce;
    logic [6:0] seg_at, seg_next;
    int hit;
    hit = -1;
    seg_at = '0;
    seg_next = '0;
    for (int i = 0; i < 5; i++) begin
      h_up = 1'b1; repeat (2) @(negedge i_Clk);
      h_up = 1'b0; repeat (2) @(negedge i_Clk);
    end
    checks++; if (h_count !== 8'h00) begin failures++; $display("FAIL bounce_filtered got=%h exp=%h", h_count, 8'h00); end
    h_up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_Clk);
      if (hit < 0 && h_count == 8'h01) begin
        hit = i;
        seg_at = h_seg[6:0];
      end else if (hit >= 0 && i == hit + 1) begin
        seg_next = h_seg[6:0];
      end
    end
    h_up = 1'b0;
    repeat (8) @(negedge i_Clk);
    checks++; if (hit != 4) begin failures++; $display("FAIL bounce_latency got=%0d exp=4", hit); end
    checks++; if (seg_at !== G0) begin failures++; $display("FAIL bounce_seg_same_cycle got=%b exp=%b", seg_at, G0); end
    checks++; if (seg_next !== G1) begin failures++; $display("FAIL bounce_seg_next got=%b exp=%b", seg_next, G1); end
    checks++; if (h_count !== 8'h01) begin failures++; $display("FAIL bounce_single_step got=%h exp=%h", h_count, 8'h01); end
    checks++; if (h_seg !== {G0, G1}) begin failures++; $display("FAIL bounce_seg_both got=%b exp=%b", h_seg, {G0, G1}); end
  endtask

  task automatic test_priority;
    for (int i = 0; i < 4; i++) press(0, 3'b001);
    checks++; if (h_count !== 8'h05) begin failures++; $display("FAIL prio_preload got=%h exp=%h", h_count, 8'h05); end
    wrap_cnt = 0;
    press(0, 3'b011);
    checks++; if (h_count !== 8'h05) begin failures++; $display("FAIL prio_up_down got=%h exp=%h", h_count, 8'h05); end
    press(0, 3'b101);
    checks++; if (h_count !== 8'h00) begin failures++; $display("FAIL prio_clear_up got=%h exp=%h", h_count, 8'h00); end
    checks++; if (wrap_cnt != 0) begin failures++; $display("FAIL prio_no_wrap got=%0d exp=0", wrap_cnt); end
  endtask

  task automatic test_wrap;
    wrap_cnt = 0;
    misaligned = 0;
    for (int i = 0; i < 255; i++) press(0, 3'b001);
    checks++; if (h_count !== 8'hFF) begin failures++; $display("FAIL wrap_preload got=%h exp=%h", h_count, 8'hFF); end
    checks++; if (h_seg !== {GF, GF}) begin failures++; $display("FAIL wrap_seg_ff got=%b exp=%b", h_seg, {GF, GF}); end
    checks++; if (wrap_cnt != 0) begin failures++; $display("FAIL wrap_none_preload got=%0d exp=0", wrap_cnt); end
    press(0, 3'b001);
    checks++; if (h_count !== 8'h00) begin failures++; $display("FAIL wrap_up_count got=%h exp=%h", h_count, 8'h00); end
    checks++; if (wrap_cnt != 1) begin failures++; $display("FAIL wrap_up_pulse got=%0d exp=1", wrap_cnt); end
    wrap_cnt = 0;
    press(0, 3'b010);
    checks++; if (h_count !== 8'hFF) begin failures++; $display("FAIL wrap_down_count got=%h exp=%h", h_count, 8'hFF); end
    checks++; if (wrap_cnt != 1) begin failures++; $display("FAIL wrap_down_pulse got=%0d exp=1", wrap_cnt); end
    checks++; if (misaligned != 0) begin failures++; $display("FAIL wrap_alignment got=%0d exp=0", misaligned); end
  endtask

  task automatic test_bcd;
    bad_digit = 0;
    wrap_cnt = 0;
    for (int i = 0; i < 9; i++) press(1, 3'b001);
    checks++; if (b_count !== 8'h09) begin failures++; $display("FAIL bcd_nine got=%h exp=%h", b_count, 8'h09); end
    press(1, 3'b001);
    checks++; if (b_count !== 8'h10) begin failures++; $display("FAIL bcd_carry got=%h exp=%h", b_count, 8'h10); end
    checks++; if (b_seg !== {G1, G0}) begin failures++; $display("FAIL bcd_seg_10 got=%b exp=%b", b_seg, {G1, G0}); end
    checks++; if (wrap_cnt != 0) begin failures++; $display("FAIL bcd_no_wrap got=%0d exp=0", wrap_cnt); end
    press(1, 3'b100);
    press(1, 3'b010);
    checks++; if (b_count !== 8'h99) begin failures++; $display("FAIL bcd_borrow got=%h exp=%h", b_count, 8'h99); end
    checks++; if (b_seg !== {G9, G9}) begin failures++; $display("FAIL bcd_seg_99 got=%b exp=%b", b_seg, {G9, G9}); end
    checks++; if (wrap_cnt != 1) begin failures++; $display("FAIL bcd_down_wrap got=%0d exp=1", wrap_cnt); end
    press(1, 3'b001);
    checks++; if (b_count !== 8'h00) begin failures++; $display("FAIL bcd_up_wrap_count got=%h exp=%h", b_count, 8'h00); end
    checks++; if (wrap_cnt != 2) begin failures++; $display("FAIL bcd_up_wrap got=%0d exp=2", wrap_cnt); end
    checks++; if (bad_digit != 0) begin failures++; $display("FAIL bcd_digit_range got=%0d exp=0", bad_digit); end
  endtask

  task automatic test_repeat;
    logic [7:0] exp;
    bit got;
    press(0, 3'b100);
    checks++; if (h_count !== 8'h00) begin failures++; $display("FAIL repeat_clear got=%h exp=%h", h_count, 8'h00); end
    got = 1'b0;
    @(negedge i_Clk);
    h_up = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge i_Clk); #1;
      if (h_count != 8'h00) got = 1'b1;
    end
    checks++; if (!got) begin failures++; $display("FAIL repeat_first_step got=timeout exp=step"); end
    // Release so the debounced level covers hold cycles 0..34.
    repeat (30) @(posedge i_Clk);
    #1 h_up = 1'b0;
    repeat (40) @(negedge i_Clk);
`ifdef UP_DOWN_COUNTER_AUTO_REPEAT_EN
    exp = 8'h04;
`else
    exp = 8'h01;
`endif
    checks++; if (h_count !== exp) begin failures++; $display("FAIL repeat_hold got=%h exp=%h", h_count, exp); end
  endtask

  task automatic test_reset_mid;
    press(0, 3'b100);
    for (int i = 0; i < 60; i++) press(0, 3'b001);
    checks++; if (h_count !== 8'h3C) begin failures++; $display("FAIL midreset_preload got=%h exp=%h", h_count, 8'h3C); end
    @(negedge i_Clk);
    h_up = 1'b1;
    repeat (2) @(negedge i_Clk);
    #2 rst_l = 1'b0;
    #1;
    checks++; if (h_count !== 8'h00) begin failures++; $display("FAIL midreset_count got=%h exp=%h", h_count, 8'h00); end
    checks++; if (h_seg !== {G0, G0}) begin failures++; $display("FAIL midreset_seg got=%b exp=%b", h_seg, {G0, G0}); end
    checks++; if (h_wrap !== 1'b0) begin failures++; $display("FAIL midreset_wrap got=%b exp=0", h_wrap); end
    h_up = 1'b0;
    repeat (2) @(negedge i_Clk);
    rst_l = 1'b1;
    repeat (12) @(negedge i_Clk);
    checks++; if (h_count !== 8'h00) begin failures++; $display("FAIL midreset_no_step got=%h exp=%h", h_count, 8'h00); end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_priority;
    test_wrap;
    test_bcd;
    test_repeat;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
